// File: rtl/act_arbiter.sv
// act_arbiter: serialises malloc (ma), dealloc (de) and check (ck) requests onto the single-ported ACT memory.
// Define ACT_ARB_RR_EN for round-robin grant (de -> ma -> ck); default is fixed priority de > ma > ck.
module act_arbiter #(
  parameter int unsigned BLOCK_COUNT_BITS = 6,
  parameter int unsigned ENTRY_W          = 32,
  parameter int unsigned GUARD_CYCLES     = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ma_req_valid,
  output logic                        ma_req_ready,
  input  logic                        ma_we,
  input  logic [BLOCK_COUNT_BITS-1:0] ma_addr,
  input  logic [ENTRY_W-1:0]          ma_wdata,
  input  logic                        de_req_valid,
  output logic                        de_req_ready,
  input  logic                        de_we,
  input  logic [BLOCK_COUNT_BITS-1:0] de_addr,
  input  logic [ENTRY_W-1:0]          de_wdata,
  input  logic                        ck_req_valid,
  output logic                        ck_req_ready,
  input  logic [BLOCK_COUNT_BITS-1:0] ck_addr,
  output logic                        ma_rsp_valid,
  output logic [ENTRY_W-1:0]          ma_rdata,
  output logic                        de_rsp_valid,
  output logic [ENTRY_W-1:0]          de_rdata,
  output logic                        ck_rsp_valid,
  output logic [ENTRY_W-1:0]          ck_rdata,
  output logic                        mem_cs,
  output logic [1:0]                  mem_op,
  output logic                        mem_ma_we,
  output logic [BLOCK_COUNT_BITS-1:0] mem_ma_addr,
  output logic [ENTRY_W-1:0]          mem_ma_wdata,
  output logic                        mem_de_we,
  output logic [BLOCK_COUNT_BITS-1:0] mem_de_addr,
  output logic [ENTRY_W-1:0]          mem_de_wdata,
  output logic [BLOCK_COUNT_BITS-1:0] mem_ck_addr,
  input  logic [ENTRY_W-1:0]          mem_ma_rdata,
  input  logic [ENTRY_W-1:0]          mem_de_rdata,
  input  logic [ENTRY_W-1:0]          mem_ck_rdata,
  input  logic                        mem_bsy,
  output logic                        arb_busy
);

  localparam int unsigned BCB   = BLOCK_COUNT_BITS;
  localparam int unsigned CNT_W = $clog2(GUARD_CYCLES + 1);

  localparam logic [1:0] OP_MALLOC  = 2'd0;
  localparam logic [1:0] OP_DEALLOC = 2'd1;
  localparam logic [1:0] OP_CHECK   = 2'd2;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_GUARD = 3'd1,
    S_IDLE  = 3'd2,
    S_ISSUE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_replay, w_replay_nxt;
  logic [1:0]        r_op;
  logic              r_ma_we, r_de_we;
  logic [BCB-1:0]    r_ma_addr, r_de_addr, r_ck_addr;
  logic [ENTRY_W-1:0] r_ma_wdata, r_de_wdata;
  logic              w_any;
  logic [1:0]        w_pick;
  logic              w_grant;

`ifdef ACT_ARB_RR_EN
  logic [1:0]        r_rr_ptr;
`endif

  // Winner selection among currently valid requesters
  always_comb begin
    w_any  = de_req_valid | ma_req_valid | ck_req_valid;
    w_pick = OP_DEALLOC;
`ifdef ACT_ARB_RR_EN
    case (r_rr_ptr)
      OP_MALLOC: w_pick = ma_req_valid ? OP_MALLOC : (ck_req_valid ? OP_CHECK : OP_DEALLOC);
      OP_CHECK:  w_pick = ck_req_valid ? OP_CHECK : (de_req_valid ? OP_DEALLOC : OP_MALLOC);
      default:   w_pick = de_req_valid ? OP_DEALLOC : (ma_req_valid ? OP_MALLOC : OP_CHECK);
    endcase
`else
    w_pick = de_req_valid ? OP_DEALLOC : (ma_req_valid ? OP_MALLOC : OP_CHECK);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_INIT;
      r_cnt    <= '0;
      r_replay <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_replay <= w_replay_nxt;
    end
  end

  // Next state and strobes; a busy memory in ISSUE parks the request for replay after GUARD
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_replay_nxt = r_replay;
    w_grant      = 1'b0;
    ma_req_ready = 1'b0;
    de_req_ready = 1'b0;
    ck_req_ready = 1'b0;
    ma_rsp_valid = 1'b0;
    de_rsp_valid = 1'b0;
    ck_rsp_valid = 1'b0;
    mem_cs       = 1'b0;
    arb_busy     = (r_state != S_IDLE);
    case (r_state)
      S_INIT: begin
        w_cnt_nxt = '0;
        if (!mem_bsy) w_state_nxt = S_GUARD;
      end
      S_GUARD: begin
        if (mem_bsy) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_INIT;
        end else if (r_cnt == CNT_W'(GUARD_CYCLES - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = r_replay ? S_ISSUE : S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (mem_bsy) begin
          w_state_nxt = S_INIT;
        end else if (w_any) begin
          w_grant      = 1'b1;
          ma_req_ready = (w_pick == OP_MALLOC);
          de_req_ready = (w_pick == OP_DEALLOC);
          ck_req_ready = (w_pick == OP_CHECK);
          w_state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_bsy) begin
          w_replay_nxt = 1'b1;
          w_state_nxt  = S_INIT;
        end else begin
          mem_cs       = 1'b1;
          w_replay_nxt = 1'b0;
          w_state_nxt  = S_RESP;
        end
      end
      S_RESP: begin
        ma_rsp_valid = (r_op == OP_MALLOC);
        de_rsp_valid = (r_op == OP_DEALLOC);
        ck_rsp_valid = (r_op == OP_CHECK);
        w_state_nxt  = mem_bsy ? S_INIT : S_IDLE;
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Latched copy of the granted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= OP_MALLOC;
      r_ma_we    <= 1'b0;
      r_ma_addr  <= '0;
      r_ma_wdata <= '0;
      r_de_we    <= 1'b0;
      r_de_addr  <= '0;
      r_de_wdata <= '0;
      r_ck_addr  <= '0;
    end else if (w_grant) begin
      r_op <= w_pick;
      case (w_pick)
        OP_MALLOC: begin
          r_ma_we    <= ma_we;
          r_ma_addr  <= ma_addr;
          r_ma_wdata <= ma_wdata;
        end
        OP_DEALLOC: begin
          r_de_we    <= de_we;
          r_de_addr  <= de_addr;
          r_de_wdata <= de_wdata;
        end
        default: r_ck_addr <= ck_addr;
      endcase
    end
  end

`ifdef ACT_ARB_RR_EN
  // Pointer moves past the requester just granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= OP_DEALLOC;
    end else if (w_grant) begin
      case (w_pick)
        OP_DEALLOC: r_rr_ptr <= OP_MALLOC;
        OP_MALLOC:  r_rr_ptr <= OP_CHECK;
        default:    r_rr_ptr <= OP_DEALLOC;
      endcase
    end
  end
`endif

  assign mem_op       = r_op;
  assign mem_ma_we    = r_ma_we;
  assign mem_ma_addr  = r_ma_addr;
  assign mem_ma_wdata = r_ma_wdata;
  assign mem_de_we    = r_de_we;
  assign mem_de_addr  = r_de_addr;
  assign mem_de_wdata = r_de_wdata;
  assign mem_ck_addr  = r_ck_addr;
  assign ma_rdata     = mem_ma_rdata;
  assign de_rdata     = mem_de_rdata;
  assign ck_rdata     = mem_ck_rdata;

endmodule

// File: tb/tb_act_arbiter.sv
// tb_act_arbiter: randomized scoreboard bench for act_arbiter with a behavioural ACT memory stand-in.
// Honours ACT_ARB_RR_EN to switch the arbitration model to round-robin.
module tb_act_arbiter;
  localparam int unsigned BCB   = 6;
  localparam int unsigned EW    = 32;
  localparam int unsigned G     = 1;
  localparam int unsigned N_ENT = 1 << BCB;

  logic clk, rst_n;
  logic ma_req_valid, ma_req_ready, ma_we;
  logic [BCB-1:0] ma_addr;
  logic [EW-1:0]  ma_wdata;
  logic de_req_valid, de_req_ready, de_we;
  logic [BCB-1:0] de_addr;
  logic [EW-1:0]  de_wdata;
  logic ck_req_valid, ck_req_ready;
  logic [BCB-1:0] ck_addr;
  logic ma_rsp_valid, de_rsp_valid, ck_rsp_valid;
  logic [EW-1:0]  ma_rdata, de_rdata, ck_rdata;
  logic mem_cs;
  logic [1:0] mem_op;
  logic mem_ma_we, mem_de_we;
  logic [BCB-1:0] mem_ma_addr, mem_de_addr, mem_ck_addr;
  logic [EW-1:0]  mem_ma_wdata, mem_de_wdata;
  logic [EW-1:0]  mem_ma_rdata, mem_de_rdata, mem_ck_rdata;
  logic mem_bsy, arb_busy;

  act_arbiter #(.BLOCK_COUNT_BITS(BCB), .ENTRY_W(EW), .GUARD_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n),
    .ma_req_valid(ma_req_valid), .ma_req_ready(ma_req_ready), .ma_we(ma_we),
    .ma_addr(ma_addr), .ma_wdata(ma_wdata),
    .de_req_valid(de_req_valid), .de_req_ready(de_req_ready), .de_we(de_we),
    .de_addr(de_addr), .de_wdata(de_wdata),
    .ck_req_valid(ck_req_valid), .ck_req_ready(ck_req_ready), .ck_addr(ck_addr),
    .ma_rsp_valid(ma_rsp_valid), .ma_rdata(ma_rdata),
    .de_rsp_valid(de_rsp_valid), .de_rdata(de_rdata),
    .ck_rsp_valid(ck_rsp_valid), .ck_rdata(ck_rdata),
    .mem_cs(mem_cs), .mem_op(mem_op),
    .mem_ma_we(mem_ma_we), .mem_ma_addr(mem_ma_addr), .mem_ma_wdata(mem_ma_wdata),
    .mem_de_we(mem_de_we), .mem_de_addr(mem_de_addr), .mem_de_wdata(mem_de_wdata),
    .mem_ck_addr(mem_ck_addr),
    .mem_ma_rdata(mem_ma_rdata), .mem_de_rdata(mem_de_rdata), .mem_ck_rdata(mem_ck_rdata),
    .mem_bsy(mem_bsy), .arb_busy(arb_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [EW-1:0] seed(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // ACT memory stand-in: read data valid only in the cycle after the strobe, junk otherwise
  logic [EW-1:0] mem [N_ENT];
  bit mem_filled;
  always @(posedge clk) begin
    if (!mem_filled) begin
      for (int i = 0; i < int'(N_ENT); i++) mem[i] <= seed(i);
      mem_filled <= 1'b1;
    end
    mem_ma_rdata <= $urandom();
    mem_de_rdata <= $urandom();
    mem_ck_rdata <= $urandom();
    if (mem_cs) begin
      case (mem_op)
        2'd0: if (mem_ma_we) mem[mem_ma_addr] <= mem_ma_wdata; else mem_ma_rdata <= mem[mem_ma_addr];
        2'd1: if (mem_de_we) mem[mem_de_addr] <= mem_de_wdata; else mem_de_rdata <= mem[mem_de_addr];
        default: mem_ck_rdata <= mem[mem_ck_addr];
      endcase
    end
  end

  typedef struct {
    int             who;
    bit             we;
    logic [BCB-1:0] addr;
    logic [EW-1:0]  wdata;
    logic [EW-1:0]  exp;
    int             acc_cyc;
    int             cs_cyc;
  } txn_t;

  txn_t          q_cs[$];
  txn_t          q_rsp[$];
  int            grant_log[$];
  logic [EW-1:0] ref_mem [N_ENT];
  int            n_vec, n_fail, cyc, rr_next;
  bit            lat_check;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // who: 0 = de, 1 = ma, 2 = ck
  function automatic logic [1:0] op_of(input int who);
    return (who == 0) ? 2'd1 : ((who == 1) ? 2'd0 : 2'd2);
  endfunction

  function automatic int pick(input logic [2:0] v, input int start);
    for (int k = 0; k < 3; k++) begin
      if (v[(start + k) % 3]) return (start + k) % 3;
    end
    return -1;
  endfunction

  function automatic bit rdy_of(input int who);
    return (who == 0) ? de_req_ready : ((who == 1) ? ma_req_ready : ck_req_ready);
  endfunction

  task automatic set_req(input int who, input bit v, input bit we, input logic [BCB-1:0] a,
                         input logic [EW-1:0] d);
    case (who)
      0: begin de_req_valid = v; de_we = we; de_addr = a; de_wdata = d; end
      1: begin ma_req_valid = v; ma_we = we; ma_addr = a; ma_wdata = d; end
      default: begin ck_req_valid = v; ck_addr = a; end
    endcase
  endtask

  task automatic monitor();
    txn_t t;
    logic [2:0] rv, vld, rdy, hs, erdy;
    int w, st;
    forever begin
      @(negedge clk);
      cyc++;
      rv = {ck_rsp_valid, ma_rsp_valid, de_rsp_valid};
      if (rv != 3'b000) begin
        if (q_rsp.size() == 0) begin
          chk("spurious_rsp", 32'(rv), 32'd0);
        end else begin
          t = q_rsp.pop_front();
          chk("rsp_who", 32'(rv), 32'(3'b001 << t.who));
          chk("rsp_lat", 32'(cyc), 32'(t.cs_cyc + 1));
          if (!t.we)
            chk("rsp_rdata", (t.who == 0) ? de_rdata : ((t.who == 1) ? ma_rdata : ck_rdata), t.exp);
        end
      end
      if (mem_cs) begin
        chk("cs_while_bsy", 32'(mem_bsy), 32'd0);
        if (q_cs.size() == 0) begin
          chk("spurious_cs", 32'(mem_cs), 32'd0);
        end else begin
          t = q_cs.pop_front();
          chk("cs_op", 32'(mem_op), 32'(op_of(t.who)));
          if (t.who == 0) begin
            chk("cs_de_addr", 32'(mem_de_addr), 32'(t.addr));
            chk("cs_de_we", 32'(mem_de_we), 32'(t.we));
            if (t.we) chk("cs_de_wdata", mem_de_wdata, t.wdata);
          end else if (t.who == 1) begin
            chk("cs_ma_addr", 32'(mem_ma_addr), 32'(t.addr));
            chk("cs_ma_we", 32'(mem_ma_we), 32'(t.we));
            if (t.we) chk("cs_ma_wdata", mem_ma_wdata, t.wdata);
          end else begin
            chk("cs_ck_addr", 32'(mem_ck_addr), 32'(t.addr));
          end
          if (lat_check) chk("cs_lat", 32'(cyc), 32'(t.acc_cyc + 1));
          t.cs_cyc = cyc;
          q_rsp.push_back(t);
        end
      end
      vld = {ck_req_valid, ma_req_valid, de_req_valid};
      rdy = {ck_req_ready, ma_req_ready, de_req_ready};
`ifdef ACT_ARB_RR_EN
      st = rr_next;
`else
      st = 0;
`endif
      erdy = 3'b000;
      if (rst_n && !arb_busy && !mem_bsy) begin
        w = pick(vld, st);
        if (w >= 0) erdy[w] = 1'b1;
      end
      chk("ready", 32'(rdy), 32'(erdy));
      hs = rdy & vld;
      if (hs != 3'b000) begin
        t.who     = hs[0] ? 0 : (hs[1] ? 1 : 2);
        t.we      = (t.who == 0) ? de_we : ((t.who == 1) ? ma_we : 1'b0);
        t.addr    = (t.who == 0) ? de_addr : ((t.who == 1) ? ma_addr : ck_addr);
        t.wdata   = (t.who == 0) ? de_wdata : ((t.who == 1) ? ma_wdata : '0);
        if (t.we) ref_mem[t.addr] = t.wdata;
        t.exp     = ref_mem[t.addr];
        t.acc_cyc = cyc;
        t.cs_cyc  = 0;
        q_cs.push_back(t);
        grant_log.push_back(t.who);
        rr_next = (t.who + 1) % 3;
      end
    end
  endtask

  task automatic do_req(input int who, input bit we, input logic [BCB-1:0] a,
                        input logic [EW-1:0] d, output longint t_acc);
    bit got;
    got   = 1'b0;
    t_acc = 0;
    set_req(who, 1'b1, we, a, d);
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (rdy_of(who)) begin
        got   = 1'b1;
        t_acc = $time;
      end
    end
    chk("req_accept", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    set_req(who, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q_cs.size() != 0 || q_rsp.size() != 0 || arb_busy) && k < 100) begin
      @(posedge clk);
      k++;
    end
    chk("drain", 32'(q_cs.size() + q_rsp.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BCB-1:0] rnd_addr();
    int r;
    r = int'($urandom_range(0, 5));
    return (r < 4) ? BCB'(r) : BCB'(N_ENT - 6 + r);
  endfunction

  initial begin
    longint t0, t1, t2;
    longint tq[$];
    logic [EW-1:0] w5;
    bit got;
    n_vec = 0; n_fail = 0; cyc = 0; rr_next = 0; lat_check = 1'b1;
    for (int i = 0; i < int'(N_ENT); i++) ref_mem[i] = seed(i);
    rst_n = 1'b0; mem_bsy = 1'b1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(2, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b1, 1'b1, 6'd7, 32'hC0FF_EE07);
    fork monitor(); join_none

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'({ck_req_ready, ma_req_ready, de_req_ready}), 32'd0);
    chk("rst_rsp", 32'({ck_rsp_valid, ma_rsp_valid, de_rsp_valid}), 32'd0);
    chk("rst_cs", 32'(mem_cs), 32'd0);
    chk("rst_op", 32'(mem_op), 32'd0);
    chk("rst_fields", 32'({mem_ma_we, mem_ma_addr, mem_de_we, mem_de_addr, mem_ck_addr}), 32'd0);
    chk("rst_wdata", mem_ma_wdata | mem_de_wdata, 32'd0);
    chk("rst_busy", 32'(arb_busy), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (17) @(posedge clk);
    #1 mem_bsy = 1'b0;

    // test 1: first grant exactly 1+G cycles after mem_bsy falls
    for (int n = 0; n <= int'(1 + G); n++) begin
      @(negedge clk);
      chk("t1_ready", 32'(ma_req_ready), 32'(n == int'(1 + G)));
    end
    @(posedge clk); #1 set_req(1, 1'b0, 1'b0, '0, '0);
    drain();

    // test 2: ma write then read back addr 5
    w5 = $urandom();
    do_req(1, 1'b1, 6'd5, w5, t0);
    do_req(1, 1'b0, 6'd5, '0, t1);
    chk("t2_spacing", 32'(t1 - t0), 32'd30);
    drain();

    // test 3: all three valid together
    fork
      do_req(0, 1'b0, 6'd5, '0, t0);
      do_req(1, 1'b1, 6'd9, $urandom(), t1);
      do_req(2, 1'b0, 6'd7, '0, t2);
    join
    tq = {t0, t1, t2};
    tq.sort();
    chk("t3_gap0", 32'(tq[1] - tq[0]), 32'd30);
    chk("t3_gap1", 32'(tq[2] - tq[1]), 32'd30);
`ifndef ACT_ARB_RR_EN
    chk("t3_de_first", 32'(t0 == tq[0]), 32'd1);
    chk("t3_ck_last", 32'(t2 == tq[2]), 32'd1);
`endif
    drain();

    // test 4: continuous pressure from all three, 12 grants
    grant_log.delete();
    fork
      for (int k = 0; k < 4; k++) do_req(0, 1'($urandom()), rnd_addr(), $urandom(), t0);
      for (int k = 0; k < 4; k++) do_req(1, 1'($urandom()), rnd_addr(), $urandom(), t1);
      for (int k = 0; k < 4; k++) do_req(2, 1'b0, rnd_addr(), '0, t2);
    join
    chk("t4_grants", 32'(grant_log.size()), 32'd12);
    for (int k = 0; k < 12 && k < grant_log.size(); k++) begin
`ifdef ACT_ARB_RR_EN
      chk("t4_rotate", 32'(grant_log[k]), 32'((grant_log[0] + k) % 3));
`else
      chk("t4_fixed", 32'(grant_log[k]), 32'(k / 4));
`endif
    end
    drain();

    // test 5: mem_bsy during ISSUE of a ck read at the top entry, replayed after GUARD
    do_req(0, 1'b1, 6'h3F, $urandom(), t0);
    drain();
    lat_check = 1'b0;
    set_req(2, 1'b1, 1'b0, 6'h3F, '0);
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (ck_req_ready) got = 1'b1;
    end
    chk("t5_accept", 32'(got), 32'd1);
    @(posedge clk);
    #1 set_req(2, 1'b0, 1'b0, '0, '0);
    mem_bsy = 1'b1;
    #1 chk("t5_cs_masked", 32'(mem_cs), 32'd0);
    repeat (4) @(posedge clk);
    #1 mem_bsy = 1'b0;
    drain();
    lat_check = 1'b1;

    // test 6: reset during RESP discards the in-flight response
    set_req(1, 1'b1, 1'b0, 6'd5, '0);
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (ma_req_ready) got = 1'b1;
    end
    chk("t6_accept", 32'(got), 32'd1);
    @(posedge clk); #1 set_req(1, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1 chk("t6_rsp_live", 32'(ma_rsp_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rsp_drop", 32'({ck_rsp_valid, ma_rsp_valid, de_rsp_valid}), 32'd0);
    chk("t6_cs_drop", 32'(mem_cs), 32'd0);
    chk("t6_busy", 32'(arb_busy), 32'd1);
    q_cs.delete();
    q_rsp.delete();
    rr_next = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    do_req(1, 1'b0, 6'd5, '0, t0);
    drain();

    // random traffic from all three requesters
    fork
      for (int k = 0; k < 10; k++) begin
        int gap = int'($urandom_range(0, 3));
        if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
        do_req(0, 1'($urandom()), rnd_addr(), $urandom(), t0);
      end
      for (int k = 0; k < 10; k++) begin
        int gap = int'($urandom_range(0, 3));
        if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
        do_req(1, 1'($urandom()), rnd_addr(), $urandom(), t1);
      end
      for (int k = 0; k < 10; k++) begin
        int gap = int'($urandom_range(0, 3));
        if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
        do_req(2, 1'b0, rnd_addr(), '0, t2);
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
